// File: rtl/mem_cycle_ctrl.sv
// mem_cycle_ctrl: bus-cycle sequencer between an 8086-style CPU bus and the
// RAM/EPROM array. Latches address/status on ALE, waits for a RD/WR command,
// drives registered selects/strobes, counts region wait states and returns READY.
module mem_cycle_ctrl #(
  parameter int RAM_WAIT   = 1,
  parameter int EPROM_WAIT = 3,
  parameter int UNMAP_WAIT = 0,
  parameter int CNTW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ale,
  input  logic       m_ioN,
  input  logic [3:0] a19to16,
  input  logic       bheN,
  input  logic       a0,
  input  logic       rdN,
  input  logic       wrN,
  output logic       ramselN,
  output logic       epromselN,
  output logic       oeN,
  output logic       wrhN,
  output logic       wrlN,
  output logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_RDY
  } state_t;

  localparam logic [CNTW-1:0] RAM_W   = CNTW'(RAM_WAIT);
  localparam logic [CNTW-1:0] EPROM_W = CNTW'(EPROM_WAIT);
  localparam logic [CNTW-1:0] UNMAP_W = CNTW'(UNMAP_WAIT);

  state_t          state, state_next;
  logic [CNTW-1:0] cnt, cnt_next;

  logic            lat_mio;
  logic [3:0]      lat_a;
  logic            lat_bhe;
  logic            lat_a0;

  logic            ramsel_next, eprom_next, oe_next, wrh_next, wrl_next;
  logic            ready_next, busy_next;

  logic            is_ram, is_eprom, cmd_active, do_latch;
  logic [CNTW-1:0] region_wait;

  // Region decode from the latched cycle information; I/O cycles never map
  always_comb begin
    is_ram   = lat_mio && (lat_a == 4'h0);
    is_eprom = lat_mio && (lat_a == 4'hf);
    if (is_ram)
      region_wait = RAM_W;
    else if (is_eprom)
      region_wait = EPROM_W;
    else
      region_wait = UNMAP_W;
    cmd_active = !rdN || !wrN;
    do_latch   = ale && ((state == S_IDLE) || (state == S_ADDR));
  end

  // Capture address/status on ALE; a second ALE in ADDR restarts the cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_mio <= 1'b0;
      lat_a   <= 4'h0;
      lat_bhe <= 1'b1;
      lat_a0  <= 1'b1;
    end else if (do_latch) begin
      lat_mio <= m_ioN;
      lat_a   <= a19to16;
      lat_bhe <= bheN;
      lat_a0  <= a0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; ALE is ignored once the command has been accepted
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (ale) state_next = S_ADDR;
      S_ADDR: begin
        if (ale)
          state_next = S_ADDR;
        else if (cmd_active)
          state_next = S_WAIT;
      end
      S_WAIT: if (cnt == '0) state_next = S_RDY;
      S_RDY:  if (rdN && wrN) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; they only move at cycle entry/exit
  always_comb begin
    cnt_next    = cnt;
    ramsel_next = ramselN;
    eprom_next  = epromselN;
    oe_next     = oeN;
    wrh_next    = wrhN;
    wrl_next    = wrlN;
    ready_next  = ready;
    busy_next   = (state_next != S_IDLE);
    case (state)
      S_ADDR: begin
        if (!ale && cmd_active) begin
          cnt_next    = region_wait;
          ramsel_next = !is_ram;
          eprom_next  = !is_eprom;
          if (!wrN) begin
            oe_next  = 1'b1;
            wrl_next = is_ram ? lat_a0  : 1'b1;
            wrh_next = is_ram ? lat_bhe : 1'b1;
          end else begin
            oe_next  = !(is_ram || is_eprom);
            wrl_next = 1'b1;
            wrh_next = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0)
          ready_next = 1'b1;
        else
          cnt_next = cnt - CNTW'(1);
      end
      S_RDY: begin
        if (rdN && wrN) begin
          ready_next  = 1'b0;
          ramsel_next = 1'b1;
          eprom_next  = 1'b1;
          oe_next     = 1'b1;
          wrh_next    = 1'b1;
          wrl_next    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and wait-counter registers; reset drops everything in one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      ramselN   <= 1'b1;
      epromselN <= 1'b1;
      oeN       <= 1'b1;
      wrhN      <= 1'b1;
      wrlN      <= 1'b1;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      ramselN   <= ramsel_next;
      epromselN <= eprom_next;
      oeN       <= oe_next;
      wrhN      <= wrh_next;
      wrlN      <= wrl_next;
      ready     <= ready_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// tb_mem_cycle_ctrl: directed bus cycles with a queue of expected select/strobe
// patterns and ready latencies built from an independent region model.
module tb_mem_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ale;
  logic       m_ioN;
  logic [3:0] a19to16;
  logic       bheN;
  logic       a0;
  logic       rdN;
  logic       wrN;
  logic       ramselN, epromselN, oeN, wrhN, wrlN, ready, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic ramsel;
    logic eprom;
    logic oe;
    logic wrh;
    logic wrl;
    int   lat;
  } exp_t;

  exp_t sb_q[$];

  mem_cycle_ctrl #(
    .RAM_WAIT(1), .EPROM_WAIT(3), .UNMAP_WAIT(0), .CNTW(4)
  ) dut (
    .clk(clk), .rst(rst), .ale(ale), .m_ioN(m_ioN), .a19to16(a19to16),
    .bheN(bheN), .a0(a0), .rdN(rdN), .wrN(wrN),
    .ramselN(ramselN), .epromselN(epromselN), .oeN(oeN), .wrhN(wrhN),
    .wrlN(wrlN), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected behaviour of one bus cycle from the CPU-side inputs
  function automatic exp_t model(input logic mio, input logic [3:0] a,
                                 input logic bhe, input logic a0v, input logic wr);
    exp_t e;
    logic ram, ep, write;
    ram   = mio && (a == 4'h0);
    ep    = mio && (a == 4'hf);
    write = !wr;
    e.ramsel = !ram;
    e.eprom  = !ep;
    e.oe     = (!write && (ram || ep)) ? 1'b0 : 1'b1;
    e.wrl    = (write && ram) ? a0v : 1'b1;
    e.wrh    = (write && ram) ? bhe : 1'b1;
    e.lat    = ram ? 2 : (ep ? 4 : 1);
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, " ramselN"}, 32'(ramselN), 1);
    check_output({tag, " epromselN"}, 32'(epromselN), 1);
    check_output({tag, " oeN"}, 32'(oeN), 1);
    check_output({tag, " wrhN"}, 32'(wrhN), 1);
    check_output({tag, " wrlN"}, 32'(wrlN), 1);
    check_output({tag, " ready"}, 32'(ready), 0);
    check_output({tag, " busy"}, 32'(busy), 0);
  endtask

  task automatic check_sel(input string tag, input exp_t e);
    check_output({tag, " ramselN"}, 32'(ramselN), 32'(e.ramsel));
    check_output({tag, " epromselN"}, 32'(epromselN), 32'(e.eprom));
    check_output({tag, " oeN"}, 32'(oeN), 32'(e.oe));
    check_output({tag, " wrhN"}, 32'(wrhN), 32'(e.wrh));
    check_output({tag, " wrlN"}, 32'(wrlN), 32'(e.wrl));
  endtask

  // Drive ALE (optionally twice), then the command; up to the select check
  task automatic start_cycle(input logic mio, input logic [3:0] a, input logic bhe,
                             input logic a0v, input logic rd, input logic wr,
                             input bit dbl, input logic [3:0] a_first);
    sb_q.push_back(model(mio, a, bhe, a0v, wr));
    @(negedge clk);
    if (dbl) begin
      ale = 1'b1; m_ioN = mio; a19to16 = a_first; bheN = bhe; a0 = a0v;
      @(negedge clk);
    end
    ale = 1'b1; m_ioN = mio; a19to16 = a; bheN = bhe; a0 = a0v;
    @(negedge clk);
    ale = 1'b0; m_ioN = 1'b0; a19to16 = 4'h7; bheN = 1'b1; a0 = 1'b1;
    rdN = rd; wrN = wr;
    @(negedge clk);
  endtask

  // Full cycle: selects on entry, ready latency, hold in RDY, clean exit
  task automatic apply_stimulus(input string tag, input logic mio, input logic [3:0] a,
                                input logic bhe, input logic a0v, input logic rd,
                                input logic wr, input bit dbl, input logic [3:0] a_first);
    exp_t e;
    int k;
    start_cycle(mio, a, bhe, a0v, rd, wr, dbl, a_first);
    e = sb_q.pop_front();
    check_sel({tag, " entry"}, e);
    check_output({tag, " busy"}, 32'(busy), 1);
    check_output({tag, " ready early"}, 32'(ready), 0);
    k = 0;
    while (ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_output({tag, " latency"}, 32'(k), 32'(e.lat));
    @(negedge clk);
    check_sel({tag, " held"}, e);
    check_output({tag, " ready held"}, 32'(ready), 1);
    rdN = 1'b1; wrN = 1'b1;
    @(negedge clk);
    check_idle({tag, " exit"});
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; ale = 1'b0; m_ioN = 1'b0; a19to16 = 4'h0; bheN = 1'b1; a0 = 1'b1;
    rdN = 1'b1; wrN = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    apply_stimulus("ram_rd",    1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    apply_stimulus("eprom_rd",  1'b1, 4'hf, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    apply_stimulus("ram_wr_lo", 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    apply_stimulus("ram_wr_hi", 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    apply_stimulus("ram_wr_w",  1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    apply_stimulus("unmap_rd",  1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    apply_stimulus("io_rd",     1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    apply_stimulus("eprom_wr",  1'b1, 4'hf, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

    // Reset while an EPROM read is still counting wait states
    start_cycle(1'b1, 4'hf, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    e = sb_q.pop_front();
    check_sel("rst_mid entry", e);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid abort");
    rst = 1'b0; rdN = 1'b1; wrN = 1'b1;
    apply_stimulus("post_rst",  1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

    apply_stimulus("rd_wr_both", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    apply_stimulus("double_ale", 1'b1, 4'hf, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
